// File: rtl/mem_responder.sv
// Byte-bus responder: synchronous byte RAM plus an IO page holding a TX FIFO,
// a sticky overflow flag and a sticky halt flag. All reads have 1-cycle latency.
module mem_responder #(
  parameter int ADDR_W     = 17,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              wr_i,
  input  logic [7:0]        wdata_i,
  output logic [7:0]        rdata_o,
  output logic [7:0]        tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output logic              halt_o,
  output logic              ovf_o
);

  localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int RAM_AW   = ADDR_W - 1;
  localparam int RAM_SIZE = 1 << RAM_AW;

  logic [7:0]       mem_q  [0:RAM_SIZE-1];
  logic [7:0]       fifo_q [0:FIFO_DEPTH-1];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             halt_q, halt_d;
  logic [7:0]       rdata_q, rdata_d;

  logic       io_sel, wr_en, ram_we;
  logic       push_req, push, pop, clr_ovf, set_halt;
  logic       full, empty;
  logic [2:0] io_reg;
  logic [7:0] io_rdata;

  // Once halted every bus write is squashed here; reads and the drain side are untouched.
  assign io_sel   = addr_i[ADDR_W-1];
  assign io_reg   = addr_i[2:0];
  assign wr_en    = wr_i & ~halt_q;
  assign ram_we   = wr_en & ~io_sel;
  assign push_req = wr_en & io_sel & (io_reg == 3'd0);
  assign clr_ovf  = wr_en & io_sel & (io_reg == 3'd3);
  assign set_halt = wr_en & io_sel & (io_reg == 3'd4);

  assign full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty = (count_q == '0);

  // TX port: a byte moves on each rising edge where tx_valid_o and tx_ready_i
  // are both high; tx_valid_o never depends on tx_ready_i, and a push into an
  // empty FIFO shows up one cycle later (no bypass).
  assign push = push_req & ~full;
  assign pop  = ~empty & tx_ready_i;

  always_comb begin
    io_rdata = 8'h00;
    unique case (io_reg)
      3'd1:    io_rdata = {5'b0, ovf_q, full, empty};
      3'd2:    io_rdata = 8'(count_q);
      3'd4:    io_rdata = {7'b0, halt_q};
      default: io_rdata = 8'h00;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    halt_d   = halt_q;
    rdata_d  = rdata_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // A push against a full FIFO is lost even if a pop frees a slot this cycle.
    if (push_req && full) ovf_d = 1'b1;
    else if (clr_ovf)     ovf_d = 1'b0;
    if (set_halt)         halt_d = 1'b1;

    if (!wr_i) rdata_d = io_sel ? io_rdata : mem_q[addr_i[RAM_AW-1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      halt_q   <= 1'b0;
      rdata_q  <= 8'h00;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      halt_q   <= halt_d;
      rdata_q  <= rdata_d;
    end
  end

  // Storage arrays carry no reset; the FIFO head is masked while empty instead.
  always_ff @(posedge clk) begin
    if (ram_we) mem_q[addr_i[RAM_AW-1:0]] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o    = rdata_q;
  assign tx_valid_o = ~empty;
  assign tx_data_o  = empty ? 8'h00 : fifo_q[rd_ptr_q];
  assign halt_o     = halt_q;
  assign ovf_o      = ovf_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a vector table for single-cycle behaviour,
// then hand-written sequences for overflow, wrap, halt and async reset.
module tb_mem_responder;

  logic        clk;
  logic        rst;
  logic [16:0] addr_i;
  logic        wr_i;
  logic [7:0]  wdata_i;
  logic [7:0]  rdata_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic        halt_o;
  logic        ovf_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  mem_responder #(.ADDR_W(17), .FIFO_DEPTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .addr_i     (addr_i),
    .wr_i       (wr_i),
    .wdata_i    (wdata_i),
    .rdata_o    (rdata_o),
    .tx_data_o  (tx_data_o),
    .tx_valid_o (tx_valid_o),
    .tx_ready_i (tx_ready_i),
    .halt_o     (halt_o),
    .ovf_o      (ovf_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic        wr;
    logic [16:0] addr;
    logic [7:0]  wdata;
    logic        ready;
    logic [7:0]  exp_rdata;
    logic        exp_valid;
    logic [7:0]  exp_txdata;
    logic        exp_halt;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[$];

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wr, input logic [16:0] a, input logic [7:0] d, input logic rdy);
    wr_i       = wr;
    addr_i     = a;
    wdata_i    = d;
    tx_ready_i = rdy;
  endtask

  task automatic add(input string n, input logic wr, input logic [16:0] a, input logic [7:0] d,
                     input logic rdy, input logic [7:0] er, input logic ev, input logic [7:0] et);
    vecs.push_back('{n, wr, a, d, rdy, er, ev, et, 1'b0, 1'b0});
  endtask

  // scoreboard
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  // Checks the visible head against the expected queue, then pops it.
  task automatic drain_check(input int n, input string name);
    logic [7:0] e;
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s.valid%0d", name, k), {7'b0, tx_valid_o}, 8'h01);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL %s.queue: got empty expected entry %0d", name, k);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("%s.head%0d", name, k), tx_data_o, e);
      end
      drive(1'b0, 17'h00010, 8'h00, 1'b1);
      step();
    end
    tx_ready_i = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] d, input logic expect_accept);
    drive(1'b1, 17'h10000, d, 1'b0);
    step();
    if (expect_accept) exp_q.push_back(d);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 17'h0, 8'h0, 1'b0);
    step();
    step();
    chk("reset.rdata", rdata_o, 8'h00);
    chk("reset.valid", {7'b0, tx_valid_o}, 8'h00);
    chk("reset.txdata", tx_data_o, 8'h00);
    chk("reset.halt", {7'b0, halt_o}, 8'h00);
    chk("reset.ovf", {7'b0, ovf_o}, 8'h00);
    rst = 1'b0;

    //  name               wr    addr       wdata  rdy   rdata  valid txdata
    add("ram_wr_10",       1'b1, 17'h00010, 8'hA5, 1'b0, 8'h00, 1'b0, 8'h00);
    add("ram_wr_ffff",     1'b1, 17'h0FFFF, 8'h5C, 1'b0, 8'h00, 1'b0, 8'h00);
    add("ram_rd_10",       1'b0, 17'h00010, 8'h00, 1'b0, 8'hA5, 1'b0, 8'h00);
    add("ram_rd_ffff",     1'b0, 17'h0FFFF, 8'h00, 1'b0, 8'h5C, 1'b0, 8'h00);
    add("ram_wr_0_hold",   1'b1, 17'h00000, 8'h11, 1'b0, 8'h5C, 1'b0, 8'h00);
    add("ram_rd_0",        1'b0, 17'h00000, 8'h00, 1'b0, 8'h11, 1'b0, 8'h00);
    add("ram_rd_10b",      1'b0, 17'h00010, 8'h00, 1'b0, 8'hA5, 1'b0, 8'h00);
    add("io_status_empty", 1'b0, 17'h10001, 8'h00, 1'b0, 8'h01, 1'b0, 8'h00);
    add("io_rd_reg3",      1'b0, 17'h10003, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00);
    add("io_rd_alias",     1'b0, 17'h1FFF9, 8'h00, 1'b0, 8'h01, 1'b0, 8'h00);
    add("io_wr_reg5",      1'b1, 17'h10005, 8'hFF, 1'b0, 8'h01, 1'b0, 8'h00);
    add("io_wr_reg1",      1'b1, 17'h10001, 8'hFF, 1'b0, 8'h01, 1'b0, 8'h00);
    add("io_count0",       1'b0, 17'h10002, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00);
    add("push_48",         1'b1, 17'h10000, 8'h48, 1'b0, 8'h00, 1'b1, 8'h48);
    add("push_69",         1'b1, 17'h10000, 8'h69, 1'b0, 8'h00, 1'b1, 8'h48);
    add("count2",          1'b0, 17'h10002, 8'h00, 1'b0, 8'h02, 1'b1, 8'h48);
    add("status_mid",      1'b0, 17'h10001, 8'h00, 1'b0, 8'h00, 1'b1, 8'h48);
    add("rd_reg4",         1'b0, 17'h10004, 8'h00, 1'b0, 8'h00, 1'b1, 8'h48);
    add("drain_48",        1'b0, 17'h10002, 8'h00, 1'b1, 8'h02, 1'b1, 8'h69);
    add("drain_69",        1'b0, 17'h10002, 8'h00, 1'b1, 8'h01, 1'b0, 8'h00);
    add("status_after",    1'b0, 17'h10001, 8'h00, 1'b0, 8'h01, 1'b0, 8'h00);
    add("io_rd_reg0",      1'b0, 17'h10000, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00);

    foreach (vecs[i]) begin
      drive(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].ready);
      step();
      chk({vecs[i].name, ".rdata"},  rdata_o, vecs[i].exp_rdata);
      chk({vecs[i].name, ".valid"},  {7'b0, tx_valid_o}, {7'b0, vecs[i].exp_valid});
      chk({vecs[i].name, ".txdata"}, tx_data_o, vecs[i].exp_txdata);
      chk({vecs[i].name, ".halt"},   {7'b0, halt_o}, {7'b0, vecs[i].exp_halt});
      chk({vecs[i].name, ".ovf"},    {7'b0, ovf_o}, {7'b0, vecs[i].exp_ovf});
    end

    // Overflow: nine pushes into an 8-deep FIFO
    for (int i = 1; i <= 8; i++) push_byte(8'(i), 1'b1);
    chk("ovf.before", {7'b0, ovf_o}, 8'h00);
    push_byte(8'd9, 1'b0);
    chk("ovf.set", {7'b0, ovf_o}, 8'h01);
    drive(1'b0, 17'h10001, 8'h00, 1'b0); step();
    chk("ovf.status", rdata_o, 8'h06);
    drive(1'b0, 17'h10002, 8'h00, 1'b0); step();
    chk("ovf.count", rdata_o, 8'h08);
    drive(1'b1, 17'h10003, 8'h5A, 1'b0); step();
    chk("ovf.cleared", {7'b0, ovf_o}, 8'h00);
    drive(1'b0, 17'h10001, 8'h00, 1'b0); step();
    chk("ovf.status2", rdata_o, 8'h02);
    drain_check(8, "ovf_drain");
    chk("ovf_drain.empty", {7'b0, tx_valid_o}, 8'h00);

    // Full FIFO with simultaneous push and pop, then 20 push/pop pairs
    for (int i = 0; i < 8; i++) push_byte(8'h20 + 8'(i), 1'b1);
    chk("fullpp.head", tx_data_o, exp_q.pop_front());
    drive(1'b1, 17'h10000, 8'hEE, 1'b1); step();
    drive(1'b0, 17'h10002, 8'h00, 1'b0); step();
    chk("fullpp.count", rdata_o, 8'h07);
    chk("fullpp.ovf", {7'b0, ovf_o}, 8'h01);
    drive(1'b1, 17'h10003, 8'h00, 1'b0); step();
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("pair%0d.valid", i), {7'b0, tx_valid_o}, 8'h01);
      chk($sformatf("pair%0d.head", i), tx_data_o, exp_q.pop_front());
      drive(1'b1, 17'h10000, 8'h80 + 8'(i), 1'b1); step();
      exp_q.push_back(8'h80 + 8'(i));
    end
    drive(1'b0, 17'h10002, 8'h00, 1'b0); step();
    chk("pairs.count", rdata_o, 8'h07);
    chk("pairs.ovf", {7'b0, ovf_o}, 8'h00);
    drain_check(7, "pairs_drain");
    chk("pairs_drain.empty", {7'b0, tx_valid_o}, 8'h00);

    // Halt: writes squashed, reads and drain continue
    drive(1'b1, 17'h00020, 8'h77, 1'b0); step();
    for (int i = 0; i < 8; i++) push_byte(8'h31 + 8'(i), 1'b1);
    push_byte(8'h39, 1'b0);
    chk("halt.pre_ovf", {7'b0, ovf_o}, 8'h01);
    chk("halt.pre_halt", {7'b0, halt_o}, 8'h00);
    drive(1'b1, 17'h10004, 8'h00, 1'b0); step();
    chk("halt.set", {7'b0, halt_o}, 8'h01);
    drive(1'b0, 17'h10004, 8'h00, 1'b0); step();
    chk("halt.read", rdata_o, 8'h01);
    drive(1'b1, 17'h10003, 8'h00, 1'b0); step();
    chk("halt.ovf_kept", {7'b0, ovf_o}, 8'h01);
    drive(1'b1, 17'h00020, 8'h33, 1'b0); step();
    drive(1'b0, 17'h00020, 8'h00, 1'b0); step();
    chk("halt.ram_kept", rdata_o, 8'h77);
    drive(1'b1, 17'h10000, 8'h99, 1'b0); step();
    drive(1'b0, 17'h10002, 8'h00, 1'b0); step();
    chk("halt.count", rdata_o, 8'h08);
    drain_check(2, "halt_drain");
    chk("halt.still", {7'b0, halt_o}, 8'h01);

    // Asynchronous reset in the middle of a drain
    drive(1'b0, 17'h10002, 8'h00, 1'b1); step();
    chk("rst.pre_rdata", rdata_o, 8'h06);
    chk("rst.pre_valid", {7'b0, tx_valid_o}, 8'h01);
    #2;
    rst = 1'b1;
    #1;
    chk("rst.valid", {7'b0, tx_valid_o}, 8'h00);
    chk("rst.txdata", tx_data_o, 8'h00);
    chk("rst.rdata", rdata_o, 8'h00);
    chk("rst.halt", {7'b0, halt_o}, 8'h00);
    chk("rst.ovf", {7'b0, ovf_o}, 8'h00);
    tx_ready_i = 1'b0;
    step();
    step();
    rst = 1'b0;
    drive(1'b0, 17'h00010, 8'h00, 1'b0); step();
    chk("post.ram10", rdata_o, 8'hA5);
    drive(1'b0, 17'h00020, 8'h00, 1'b0); step();
    chk("post.ram20", rdata_o, 8'h77);
    drive(1'b0, 17'h10001, 8'h00, 1'b0); step();
    chk("post.status", rdata_o, 8'h01);
    drive(1'b1, 17'h10000, 8'h5A, 1'b0); step();
    chk("post.push_valid", {7'b0, tx_valid_o}, 8'h01);
    chk("post.push_data", tx_data_o, 8'h5A);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
